cpu_mem_responder: RTL and testbench

- Memory-side responder for the pipelined CPU's two memory ports: instruction fetch (o_pc_*) and load/store (o_ldst_*).
- Holds a word-addressed RAM shared by both ports, with fixed 1-cycle registered read latency to match the fetch→rf_read and rf_read→execute pipeline timing.
- Adds a small MMIO region: LED register, free-running cycle counter, sticky error status.
- Sits at top level beside cpu; its outputs drive the CPU's i_pc_rddata and i_ldst_rddata.

---
 rtl/cpu_mem_responder.sv | 87 ++++++++
 tb/tb_cpu_mem_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU fetch and load/store ports: shared word RAM
// with 1-cycle registered reads, plus LED, cycle-counter and sticky-status MMIO.
module cpu_mem_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int LED_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      i_pc_addr,
    input  logic             i_pc_rd,
    output logic [15:0]      o_pc_rddata,
    input  logic [15:0]      i_ldst_addr,
    input  logic             i_ldst_rd,
    input  logic             i_ldst_wr,
    input  logic [15:0]      i_ldst_wrdata,
    output logic [15:0]      o_ldst_rddata,
    output logic [LED_W-1:0] o_leds,
    output logic [1:0]       o_err
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [14:0] RAM_LIMIT = 15'(DEPTH_WORDS);
    localparam logic [14:0] LED_IDX   = 15'h7800;
    localparam logic [14:0] CNT_IDX   = 15'h7801;
    localparam logic [14:0] STAT_IDX  = 15'h7802;

    logic [15:0] ram [DEPTH_WORDS];
    logic [15:0] cycle_cnt;

    logic [14:0] pc_widx, ls_widx;
    logic        pc_in_ram, ls_in_ram, ls_is_led, ls_is_cnt, ls_is_stat, ls_mapped;
    logic        ls_access;
    logic [1:0]  err_set, err_clr;
    logic [15:0] ls_rd_val;

    // Decode ignores addr[0]: misaligned accesses still hit the word at addr[15:1]
    assign pc_widx    = i_pc_addr[15:1];
    assign ls_widx    = i_ldst_addr[15:1];
    assign pc_in_ram  = pc_widx < RAM_LIMIT;
    assign ls_in_ram  = ls_widx < RAM_LIMIT;
    assign ls_is_led  = ls_widx == LED_IDX;
    assign ls_is_cnt  = ls_widx == CNT_IDX;
    assign ls_is_stat = ls_widx == STAT_IDX;
    assign ls_mapped  = ls_in_ram | ls_is_led | ls_is_cnt | ls_is_stat;
    assign ls_access  = i_ldst_rd | i_ldst_wr;

    assign err_set[0] = (i_pc_rd & i_pc_addr[0]) | (ls_access & i_ldst_addr[0]);
    assign err_set[1] = (i_pc_rd & ~pc_in_ram) | (ls_access & ~ls_mapped);
    assign err_clr    = (i_ldst_wr && ls_is_stat) ? i_ldst_wrdata[1:0] : 2'b00;

    always_comb begin
        ls_rd_val = '0;
        if (ls_in_ram)
            ls_rd_val = ram[ls_widx[AW-1:0]];
        else if (ls_is_led)
            ls_rd_val = 16'(o_leds);
        else if (ls_is_cnt)
            ls_rd_val = cycle_cnt;
        else if (ls_is_stat)
            ls_rd_val = {14'b0, o_err};
    end

    // RAM is not reset; non-blocking write gives read-first on a same-cycle fetch
    always_ff @(posedge clk) begin
        if (i_ldst_wr && ls_in_ram)
            ram[ls_widx[AW-1:0]] <= i_ldst_wrdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_pc_rddata   <= '0;
            o_ldst_rddata <= '0;
            o_leds        <= '0;
            o_err         <= '0;
            cycle_cnt     <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
            if (i_pc_rd)
                o_pc_rddata <= pc_in_ram ? ram[pc_widx[AW-1:0]] : 16'h0000;
            if (i_ldst_rd && !i_ldst_wr)
                o_ldst_rddata <= ls_rd_val;
            if (i_ldst_wr && ls_is_led)
                o_leds <= i_ldst_wrdata[LED_W-1:0];
            // Set beats clear when both hit the same bit in one cycle
            o_err <= (o_err & ~err_clr) | err_set;
        end
    end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: fetch/load latency, MMIO, sticky errors,
// counter wrap and async reset.
module tb_cpu_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_addr;
    logic        pc_rd;
    logic [15:0] pc_rddata;
    logic [15:0] ldst_addr;
    logic        ldst_rd;
    logic        ldst_wr;
    logic [15:0] ldst_wrdata;
    logic [15:0] ldst_rddata;
    logic [7:0]  leds;
    logic [1:0]  err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] cnt_a, cnt_b;

    cpu_mem_responder #(.DEPTH_WORDS(4096), .LED_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_pc_addr     (pc_addr),
        .i_pc_rd       (pc_rd),
        .o_pc_rddata   (pc_rddata),
        .i_ldst_addr   (ldst_addr),
        .i_ldst_rd     (ldst_rd),
        .i_ldst_wr     (ldst_wr),
        .i_ldst_wrdata (ldst_wrdata),
        .o_ldst_rddata (ldst_rddata),
        .o_leds        (leds),
        .o_err         (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ls(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] data);
        ldst_rd     = rd;
        ldst_wr     = wr;
        ldst_addr   = addr;
        ldst_wrdata = data;
    endtask

    task automatic set_pc(input logic rd, input logic [15:0] addr);
        pc_rd   = rd;
        pc_addr = addr;
    endtask

    initial begin
        reset = 1'b0;
        set_pc(1'b0, 16'h0000);
        set_ls(1'b0, 1'b0, 16'h0000, 16'h0000);
        #2;
        check_val("rst_pc", pc_rddata, 16'h0000);
        check_val("rst_ls", ldst_rddata, 16'h0000);
        check_val("rst_leds", 16'(leds), 16'h0000);
        check_val("rst_err", 16'(err), 16'h0000);
        #10 reset = 1'b1;

        // Preload through the store port
        set_ls(1'b0, 1'b1, 16'h0000, 16'h1234); tick();
        set_ls(1'b0, 1'b1, 16'h0002, 16'hABCD); tick();
        set_ls(1'b0, 1'b1, 16'h0100, 16'h1111); tick();
        set_ls(1'b0, 1'b0, 16'h0000, 16'h0000);

        // Fetch latency and hold
        set_pc(1'b1, 16'h0000); tick();
        check_val("fetch0", pc_rddata, 16'h1234);
        set_pc(1'b1, 16'h0002); tick();
        check_val("fetch1", pc_rddata, 16'hABCD);
        set_pc(1'b0, 16'h0000); tick();
        check_val("fetch_hold", pc_rddata, 16'hABCD);
        check_val("err_clean", 16'(err), 16'h0000);

        // Store with same-cycle fetch of the same word: old data first
        set_pc(1'b1, 16'h0100);
        set_ls(1'b0, 1'b1, 16'h0100, 16'h5A5A); tick();
        check_val("fetch_rdfirst", pc_rddata, 16'h1111);
        set_ls(1'b1, 1'b0, 16'h0100, 16'h0000); tick();
        check_val("fetch_new", pc_rddata, 16'h5A5A);
        check_val("load_new", ldst_rddata, 16'h5A5A);
        set_pc(1'b0, 16'h0000);

        // LED register
        set_ls(1'b0, 1'b1, 16'hF000, 16'h00FF); tick();
        check_val("leds_wr", 16'(leds), 16'h00FF);
        set_ls(1'b1, 1'b0, 16'hF000, 16'h0000); tick();
        check_val("leds_rd", ldst_rddata, 16'h00FF);
        set_ls(1'b1, 1'b1, 16'hF000, 16'h0012); tick();
        check_val("rdwr_hold", ldst_rddata, 16'h00FF);
        check_val("rdwr_leds", 16'(leds), 16'h0012);
        check_val("rdwr_err", 16'(err), 16'h0000);

        // Counter reads five edges apart
        set_ls(1'b1, 1'b0, 16'hF002, 16'h0000); tick();
        cnt_a = ldst_rddata;
        set_ls(1'b0, 1'b0, 16'hF002, 16'h0000);
        repeat (4) tick();
        set_ls(1'b1, 1'b0, 16'hF002, 16'h0000); tick();
        cnt_b = ldst_rddata;
        check_val("cnt_delta", cnt_b - cnt_a, 16'd5);

        // Error handling
        set_ls(1'b1, 1'b0, 16'h0101, 16'h0000); tick();
        check_val("misalign_err", 16'(err), 16'h0001);
        check_val("misalign_data", ldst_rddata, 16'h5A5A);
        set_ls(1'b0, 1'b1, 16'h8000, 16'hDEAD); tick();
        check_val("unmap_st_err", 16'(err), 16'h0003);
        set_ls(1'b1, 1'b0, 16'h0000, 16'h0000); tick();
        check_val("unmap_st_ram", ldst_rddata, 16'h1234);
        set_ls(1'b0, 1'b1, 16'hF004, 16'h0001); tick();
        check_val("clr_bit0", 16'(err), 16'h0002);
        set_ls(1'b1, 1'b0, 16'hF004, 16'h0000); tick();
        check_val("stat_rd", ldst_rddata, 16'h0002);
        set_ls(1'b0, 1'b1, 16'hF004, 16'h0003); tick();
        check_val("clr_all", 16'(err), 16'h0000);

        // Unmapped fetch and load together
        set_pc(1'b1, 16'h9000);
        set_ls(1'b1, 1'b0, 16'h9000, 16'h0000); tick();
        check_val("unmap_both_err", 16'(err), 16'h0002);
        check_val("unmap_pc", pc_rddata, 16'h0000);
        check_val("unmap_ls", ldst_rddata, 16'h0000);
        set_pc(1'b0, 16'h0000);

        // Set beats clear
        set_ls(1'b1, 1'b0, 16'h9001, 16'h0000); tick();
        check_val("both_set", 16'(err), 16'h0003);
        set_pc(1'b1, 16'h0001);
        set_ls(1'b0, 1'b1, 16'hF004, 16'h0003); tick();
        check_val("set_wins", 16'(err), 16'h0001);
        check_val("misalign_fetch", pc_rddata, 16'h1234);
        set_pc(1'b0, 16'h0000);
        set_ls(1'b1, 1'b0, 16'h0100, 16'h0000); tick();

        // Async reset between edges
        #3 reset = 1'b0;
        #1;
        check_val("arst_pc", pc_rddata, 16'h0000);
        check_val("arst_ls", ldst_rddata, 16'h0000);
        check_val("arst_leds", 16'(leds), 16'h0000);
        check_val("arst_err", 16'(err), 16'h0000);
        set_ls(1'b1, 1'b0, 16'hF002, 16'h0000);
        #1 reset = 1'b1;
        tick();
        check_val("cnt_restart", ldst_rddata, 16'h0000);
        repeat (65534) tick();
        tick();
        check_val("cnt_ffff", ldst_rddata, 16'hFFFF);
        tick();
        check_val("cnt_wrap", ldst_rddata, 16'h0000);
        set_ls(1'b1, 1'b0, 16'h0100, 16'h0000); tick();
        check_val("ram_keep", ldst_rddata, 16'h5A5A);
        set_pc(1'b1, 16'h0002); tick();
        check_val("ram_keep_pc", pc_rddata, 16'hABCD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
